trig_link_tx: RTL and testbench

Transmitter end of the coax trigger link between a digitizer board and the trigger board. The receiver locks its phase by counting sync pulses across 4 phase bins, then decodes phase-aligned trigger pulses. This block does two things:
- When the trigger board raises its sync-window line, it emits a fixed train of phase-0 sync pulses on every channel.
- Otherwise it forwards per-channel trigger requests as one-tick pulses aligned to local phase 0 of a free-running 4-tick counter.

---
 rtl/trig_link_tx.sv | 157 +++++++++++++++
 tb/tb_trig_link_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/trig_link_tx.sv
// Coax trigger link transmitter: forwards trigger requests aligned to local phase 0
// and emits a fixed sync-pulse train whenever the trigger board opens a sync window.
module trig_link_tx #(
    parameter int NCH         = 4,
    parameter int QUIET_TICKS = 250,
    parameter int NSYNC       = 64
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           sync_req,
    input  logic [NCH-1:0] trig_in,
    output logic [NCH-1:0] coax_out,
    output logic [1:0]     phase,
    output logic           sync_busy,
    output logic           sync_done,
    output logic           sync_abort,
    output logic [15:0]    dropped_cnt
);

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        QUIET    = 2'd1,
        SYNC     = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    localparam logic [15:0] QUIET_LAST = 16'(QUIET_TICKS - 1);
    localparam logic [15:0] NSYNC_LAST = 16'(NSYNC - 1);

    state_t         state, state_nx;
    logic           sreq_meta, sreq_s, sreq_d;
    logic           rise;
    logic [NCH-1:0] pending, pending_nx;
    logic [NCH-1:0] coax_nx;
    logic [15:0]    qcnt, qcnt_nx;
    logic [15:0]    scnt, scnt_nx;
    logic [15:0]    dropped_nx;
    logic           done_nx, abort_nx;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Synchronizer resets high so a window already open at reset release yields no rise.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sreq_meta <= 1'b1;
            sreq_s    <= 1'b1;
            sreq_d    <= 1'b1;
        end else begin
            sreq_meta <= sync_req;
            sreq_s    <= sreq_meta;
            sreq_d    <= sreq_s;
        end
    end

    assign rise = sreq_s & ~sreq_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase <= 2'd0;
        end else begin
            phase <= phase + 2'd1;
        end
    end

    always_comb begin
        state_nx   = state;
        coax_nx    = '0;
        pending_nx = pending;
        qcnt_nx    = qcnt;
        scnt_nx    = scnt;
        done_nx    = 1'b0;
        abort_nx   = 1'b0;
        dropped_nx = dropped_cnt;

        // Any trigger activity while the link is owned by the sync window is lost.
        if ((state != NORMAL) && (|trig_in)) begin
            dropped_nx = sat_inc16(dropped_cnt);
        end

        case (state)
            NORMAL: begin
                pending_nx = pending | trig_in;
                if (phase == 2'd0) begin
                    coax_nx    = pending | trig_in;
                    pending_nx = '0;
                end
                if (rise) begin
                    state_nx   = QUIET;
                    pending_nx = '0;
                    qcnt_nx    = '0;
                end
            end
            QUIET: begin
                qcnt_nx = qcnt + 16'd1;
                if (!sreq_s) begin
                    state_nx   = NORMAL;
                    abort_nx   = 1'b1;
                    pending_nx = '0;
                end else if (qcnt == QUIET_LAST) begin
                    state_nx = SYNC;
                    scnt_nx  = '0;
                end
            end
            SYNC: begin
                if (!sreq_s) begin
                    state_nx   = NORMAL;
                    abort_nx   = 1'b1;
                    pending_nx = '0;
                end else if (phase == 2'd0) begin
                    coax_nx = '1;
                    scnt_nx = scnt + 16'd1;
                    if (scnt == NSYNC_LAST) begin
                        done_nx  = 1'b1;
                        state_nx = WAIT_END;
                    end
                end
            end
            WAIT_END: begin
                if (!sreq_s) begin
                    state_nx   = NORMAL;
                    pending_nx = '0;
                end
            end
            default: begin
                state_nx   = NORMAL;
                pending_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= NORMAL;
            coax_out    <= '0;
            pending     <= '0;
            qcnt        <= '0;
            scnt        <= '0;
            sync_done   <= 1'b0;
            sync_abort  <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            state       <= state_nx;
            coax_out    <= coax_nx;
            pending     <= pending_nx;
            qcnt        <= qcnt_nx;
            scnt        <= scnt_nx;
            sync_done   <= done_nx;
            sync_abort  <= abort_nx;
            dropped_cnt <= dropped_nx;
        end
    end

    assign sync_busy = (state != NORMAL);

endmodule

// File: tb/tb_trig_link_tx.sv
// Directed bench for trig_link_tx: forwarding, held triggers, full sync train,
// drop counting and saturation, abort, and async reset with the window still open.
module tb_trig_link_tx;

    localparam int NCH = 4;
    localparam int QT  = 250;
    localparam int NS  = 64;

    logic           clk = 1'b0;
    logic           nrst;
    logic           sync_req;
    logic [NCH-1:0] trig_in;
    logic [NCH-1:0] coax_out;
    logic [1:0]     phase;
    logic           sync_busy;
    logic           sync_done;
    logic           sync_abort;
    logic [15:0]    dropped_cnt;

    int checks   = 0;
    int failures = 0;
    int nz, bz, lat, pulses, last, first, gap_bad, hex_bad, done_cnt, done_bad, ab, dn;

    always #5 clk = ~clk;

    trig_link_tx #(
        .NCH        (NCH),
        .QUIET_TICKS(QT),
        .NSYNC      (NS)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .sync_req   (sync_req),
        .trig_in    (trig_in),
        .coax_out   (coax_out),
        .phase      (phase),
        .sync_busy  (sync_busy),
        .sync_done  (sync_done),
        .sync_abort (sync_abort),
        .dropped_cnt(dropped_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int i = 0; i < 8 && phase != p; i++) tick();
        check_eq("wait_phase", 32'(phase), 32'(p));
    endtask

    task automatic wait_busy(input logic lvl, output int n);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (sync_busy == lvl) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        nrst     = 1'b0;
        sync_req = 1'b0;
        trig_in  = '0;
        repeat (3) tick();
        check_eq("rst_coax", 32'(coax_out), 32'd0);
        check_eq("rst_phase", 32'(phase), 32'd0);
        check_eq("rst_busy", 32'(sync_busy), 32'd0);
        check_eq("rst_done", 32'(sync_done), 32'd0);
        check_eq("rst_abort", 32'(sync_abort), 32'd0);
        check_eq("rst_dropped", 32'(dropped_cnt), 32'd0);
        nrst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq("phase_run", 32'(phase), 32'(k % 4));
        end

        // Single-cycle trigger at phase 2 -> one pulse observed at phase 1
        wait_phase(2'd2);
        trig_in = 4'b0100;
        tick();
        trig_in = '0;
        tick();
        check_eq("fwd_p0", 32'(coax_out), 32'd0);
        tick();
        check_eq("fwd_pulse", 32'(coax_out), 32'(4'b0100));
        nz = 0;
        repeat (6) begin
            tick();
            if (coax_out != '0) nz++;
        end
        check_eq("fwd_single", 32'(nz), 32'd0);

        // Held trigger for 20 clk from phase 1 -> 5 pulses, 4 clk apart, in phase-1 cycles
        wait_phase(2'd1);
        trig_in = 4'b0001;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 20) trig_in = '0;
            check_eq("held", 32'(coax_out), (k % 4 == 0 && k <= 20) ? 32'd1 : 32'd0);
        end

        // Full sync window
        sync_req = 1'b1;
        wait_busy(1'b1, lat);
        check_eq("busy_lat_ok", 32'(lat >= 2 && lat <= 4), 32'd1);
        nz = 0;
        trig_in = 4'b0011;
        repeat (10) begin
            tick();
            if (coax_out != '0) nz++;
        end
        trig_in = '0;
        check_eq("drop10", 32'(dropped_cnt), 32'd10);
        for (int k = 11; k <= QT; k++) begin
            tick();
            if (coax_out != '0) nz++;
        end
        check_eq("quiet_silent", 32'(nz), 32'd0);

        pulses = 0; last = -1; first = 0; gap_bad = 0; hex_bad = 0; done_cnt = 0; done_bad = 0;
        for (int k = QT + 1; k <= QT + 301; k++) begin
            tick();
            if (coax_out != '0) begin
                pulses++;
                if (coax_out != 4'hF) hex_bad++;
                if (last >= 0 && k - last != 4) gap_bad++;
                if (last < 0) first = k;
                last = k;
            end
            if (sync_done) begin
                done_cnt++;
                if (coax_out != 4'hF || pulses != NS) done_bad++;
            end
        end
        check_eq("train_pulses", 32'(pulses), 32'(NS));
        check_eq("train_allones", 32'(hex_bad), 32'd0);
        check_eq("train_spacing", 32'(gap_bad), 32'd0);
        check_eq("train_first_ok", 32'(first >= QT + 1 && first <= QT + 4), 32'd1);
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("done_on_last", 32'(done_bad), 32'd0);

        // Drop saturation while waiting for the window to close
        nz = 0;
        trig_in = 4'b0001;
        repeat (70000) begin
            tick();
            if (coax_out != '0) nz++;
        end
        trig_in = '0;
        check_eq("drop_sat", 32'(dropped_cnt), 32'hFFFF);
        check_eq("wait_silent", 32'(nz), 32'd0);
        check_eq("wait_busy", 32'(sync_busy), 32'd1);
        sync_req = 1'b0;
        wait_busy(1'b0, lat);
        check_eq("unbusy_lat_ok", 32'(lat >= 2 && lat <= 4), 32'd1);

        // Abort after 30 sync pulses
        sync_req = 1'b1;
        wait_busy(1'b1, lat);
        check_eq("abort_busy", 32'(lat != 0), 32'd1);
        pulses = 0;
        for (int i = 0; i < 600 && pulses < 30; i++) begin
            tick();
            if (coax_out != '0) pulses++;
        end
        check_eq("abort_30", 32'(pulses), 32'd30);
        sync_req = 1'b0;
        ab = 0; nz = 0; dn = 0;
        repeat (12) begin
            tick();
            if (sync_abort) ab++;
            if (coax_out != '0) nz++;
            if (sync_done) dn++;
        end
        check_eq("abort_once", 32'(ab), 32'd1);
        check_eq("abort_silent", 32'(nz), 32'd0);
        check_eq("abort_nodone", 32'(dn), 32'd0);
        check_eq("abort_idle", 32'(sync_busy), 32'd0);
        wait_phase(2'd2);
        trig_in = 4'b1000;
        tick();
        trig_in = '0;
        tick();
        tick();
        check_eq("resume_fwd", 32'(coax_out), 32'(4'b1000));

        // Async reset mid-train with sync_req still high
        sync_req = 1'b1;
        wait_busy(1'b1, lat);
        pulses = 0;
        for (int i = 0; i < 600 && pulses < 5; i++) begin
            tick();
            if (coax_out != '0) pulses++;
        end
        check_eq("rst_pre_pulses", 32'(pulses), 32'd5);
        nrst = 1'b0;
        #1;
        check_eq("arst_coax", 32'(coax_out), 32'd0);
        check_eq("arst_busy", 32'(sync_busy), 32'd0);
        check_eq("arst_done", 32'(sync_done), 32'd0);
        check_eq("arst_abort", 32'(sync_abort), 32'd0);
        check_eq("arst_dropped", 32'(dropped_cnt), 32'd0);
        check_eq("arst_phase", 32'(phase), 32'd0);
        repeat (2) tick();
        nrst = 1'b1;
        nz = 0; bz = 0;
        repeat (400) begin
            tick();
            if (coax_out != '0) nz++;
            if (sync_busy) bz++;
        end
        check_eq("postrst_silent", 32'(nz), 32'd0);
        check_eq("postrst_idle", 32'(bz), 32'd0);
        sync_req = 1'b0;
        repeat (6) tick();
        sync_req = 1'b1;
        wait_busy(1'b1, lat);
        check_eq("retoggle_busy", 32'(sync_busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
